// File: rtl/gate_pkg.sv
// Shared definitions for the arbitrated bitwise gate unit: op codes and FSM states.
package gate_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOT  = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/gate_op_unit.sv
// Combinational DATA_W-bit bitwise gate; every 3-bit op code is legal.
module gate_op_unit
    import gate_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        case (op_e'(op))
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_NOT:  y = ~a;
            OP_PASS: y = a;
        endcase
    end

endmodule

// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter sharing one gate_op_unit among NUM_REQ requesters,
// with a single registered, ID-tagged response channel.
module gate_unit_arbiter
    import gate_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 4,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [3*NUM_REQ-1:0]      req_op,
    input  logic [DATA_W*NUM_REQ-1:0] req_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    output logic [7:0]                busy_cnt
);

    state_e            state;
    state_e            state_next;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   win_idx;
    logic [ID_W-1:0]   scan_idx;
    logic              win_found;
    logic              accept;
    logic [2:0]        sel_op;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [DATA_W-1:0] gate_y;

    // Scan starts one past the last winner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            scan_idx = ID_W'((32'(rr_ptr) + off) % NUM_REQ);
            if (!win_found && req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx == ID_W'(i)) begin
                sel_op = req_op[3*i +: 3];
                sel_a  = req_a[DATA_W*i +: DATA_W];
                sel_b  = req_b[DATA_W*i +: DATA_W];
            end
        end
    end

    gate_op_unit #(
        .DATA_W (DATA_W)
    ) u_gate (
        .op (sel_op),
        .a  (sel_a),
        .b  (sel_b),
        .y  (gate_y)
    );

    assign accept = |req_ready;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_HOLD;
            ST_HOLD: if (rsp_ready && !accept) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs; HOLD may accept only when the current result drains this cycle
    always_comb begin
        req_ready = '0;
        rsp_valid = (state == ST_HOLD);
        if (!rst && win_found && (state == ST_IDLE || rsp_ready)) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data <= '0;
            rsp_id   <= '0;
            rr_ptr   <= ID_W'(NUM_REQ - 1);
            busy_cnt <= '0;
        end else if (accept) begin
            rsp_data <= gate_y;
            rsp_id   <= win_idx;
            rr_ptr   <= win_idx;
            if (busy_cnt != 8'hFF) begin
                busy_cnt <= busy_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Scoreboard bench for gate_unit_arbiter: a reference arbiter model pushes
// expected results on acceptance; they are popped as responses drain.
module tb_gate_unit_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [11:0] req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic [7:0]  busy_cnt;

    gate_unit_arbiter #(
        .NUM_REQ (4),
        .DATA_W  (4),
        .ID_W    (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy_cnt  (busy_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] data;
        logic [1:0] id;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad   = 0;
    bit         m_hold;
    int         m_rr;
    int         m_cnt;
    int         m_last;
    logic [3:0] sweep_tbl [8];
    int         rr_order  [5];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~(a & b);
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    task automatic set_req(input int i, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        req_op[3*i +: 3] = op;
        req_a[4*i +: 4]  = a;
        req_b[4*i +: 4]  = b;
    endtask

    // One clock: check outputs against the model, drain/push the scoreboard, advance the model.
    task automatic step();
        logic [3:0] exp_ready;
        bit         acc;
        int         w;
        int         idx;
        exp_t       e;
        #1;
        exp_ready = '0;
        acc = 1'b0;
        w = 0;
        if (!rst && (!m_hold || rsp_ready)) begin
            for (int off = 1; off <= 4; off++) begin
                idx = (m_rr + off) % 4;
                if (!acc && req_valid[idx]) begin
                    acc = 1'b1;
                    w = idx;
                end
            end
        end
        if (acc) exp_ready[w] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("rsp_valid", 32'(rsp_valid), 32'(m_hold));
        check("busy_cnt", 32'(busy_cnt), 32'(m_cnt));
        if (m_hold) begin
            if (sb.size() == 0) begin
                check("sb_size", 32'(sb.size()), 32'd1);
            end else begin
                check("rsp_data", 32'(rsp_data), 32'(sb[0].data));
                check("rsp_id", 32'(rsp_id), 32'(sb[0].id));
                if (rsp_ready && !rst) void'(sb.pop_front());
            end
        end
        if (acc) begin
            e.data = model_op(req_op[3*w +: 3], req_a[4*w +: 4], req_b[4*w +: 4]);
            e.id   = 2'(w);
            sb.push_back(e);
        end
        @(posedge clk);
        if (rst) begin
            m_hold = 1'b0;
            m_rr   = 3;
            m_cnt  = 0;
            sb.delete();
        end else begin
            if (acc) begin
                m_rr   = w;
                m_last = w;
                if (m_cnt < 255) m_cnt++;
            end
            m_hold = acc || (m_hold && !rsp_ready);
        end
        @(negedge clk);
    endtask

    initial begin
        sweep_tbl[0] = 4'h1; sweep_tbl[1] = 4'hD; sweep_tbl[2] = 4'hE; sweep_tbl[3] = 4'h2;
        sweep_tbl[4] = 4'hC; sweep_tbl[5] = 4'h3; sweep_tbl[6] = 4'h6; sweep_tbl[7] = 4'h9;
        rr_order[0] = 0; rr_order[1] = 1; rr_order[2] = 2; rr_order[3] = 3; rr_order[4] = 0;
        m_hold = 1'b0; m_rr = 3; m_cnt = 0; m_last = 0;

        // Reset with every requester asking
        rst = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        req_op = '0; req_a = '0; req_b = '0;
        @(posedge clk);
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        req_valid = '0;

        // Single NAND from requester 0
        set_req(0, 3'd2, 4'hC, 4'hA);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        #1;
        check("nand_data", 32'(rsp_data), 32'h7);
        check("nand_id", 32'(rsp_id), 32'h0);
        step();

        // Round-robin from a fresh reset pointer
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 3'(i), 4'(i + 3), 4'hA);
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_order", 32'(req_ready), 32'(4'b0001 << rr_order[k]));
            step();
        end
        req_valid = '0;
        #1;
        check("rr_busy_cnt", 32'(busy_cnt), 32'd5);
        step();

        // Backpressure holds the XOR result and blocks new grants
        set_req(1, 3'd4, 4'h5, 4'h3);
        req_valid = 4'b0010;
        step();
        set_req(2, 3'd0, 4'hF, 4'hA);
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_data", 32'(rsp_data), 32'h6);
            check("bp_ready", 32'(req_ready), 32'h0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        #1;
        check("b2b_data", 32'(rsp_data), 32'hA);
        check("b2b_id", 32'(rsp_id), 32'h2);
        step();

        // Reset while a result is pending
        set_req(3, 3'd5, 4'hF, 4'h0);
        req_valid = 4'b1000;
        rsp_ready = 1'b0;
        step();
        req_valid = '0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 4'hF;
        #1;
        check("rst_mid_valid", 32'(rsp_valid), 32'h0);
        check("rst_mid_winner", 32'(req_ready), 32'b0001);
        rsp_ready = 1'b1;
        step();
        req_valid = '0;
        step();

        // Saturate the accepted-op counter
        for (int i = 0; i < 4; i++) set_req(i, 3'($urandom_range(7)), 4'($urandom), 4'($urandom));
        req_valid = 4'hF;
        for (int k = 0; k < 260; k++) begin
            step();
            set_req(m_last, 3'($urandom_range(7)), 4'($urandom), 4'($urandom));
        end
        req_valid = '0;
        #1;
        check("sat_cnt", 32'(busy_cnt), 32'hFF);
        step();

        // Full op sweep on requester 0
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) begin
                set_req(0, 3'(k), 4'h9, 4'h5);
                req_valid = 4'b0001;
            end else begin
                req_valid = '0;
            end
            #1;
            if (k > 0) check("sweep", 32'(rsp_data), 32'(sweep_tbl[k-1]));
            step();
        end
        check("sat_hold", 32'(busy_cnt), 32'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
